// File: rtl/step_controller.sv
`default_nettype none
// ============================================================================
// Module   : step_controller
// Purpose  : Decides on which cycles the single-cycle CPU advances; manual,
//            free-run, burst and run-to-breakpoint modes.
// Revision : 1.0
// ============================================================================
module step_controller #(
    parameter int PC_WIDTH    = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic                   step_pulse,
    input  logic                   tick,
    input  logic [BURST_WIDTH-1:0] burst_count,
    input  logic [PC_WIDTH-1:0]    breakpoint,
    input  logic                   bp_enable,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   halt_req,
    output logic                   cpu_enable,
    output logic                   cpu_reset,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [1:0]             state,
    output logic                   halted
);

    typedef enum logic [1:0] {
        S_RESET_SEQ = 2'b00,
        S_IDLE      = 2'b01,
        S_RUN       = 2'b10,
        S_HALTED    = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             run_mode_q, run_mode_d;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
    logic                   first_q, first_d;
    logic                   enable_q, enable_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   halted_q, halted_d;
    logic                   bp_hit;
    logic                   issue_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RESET_SEQ;
            run_mode_q  <= 2'b00;
            remaining_q <= '0;
            first_q     <= 1'b0;
            enable_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            count_q     <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_mode_q  <= run_mode_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            enable_q    <= enable_d;
            cpu_reset_q <= cpu_reset_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
        end
    end

    // first_q masks a breakpoint on the PC a run was started from
    assign bp_hit    = bp_enable && (pc == breakpoint) && !first_q;
    assign issue_req = (run_mode_q == 2'b11) || tick;

    always_comb begin
        state_d     = state_q;
        run_mode_d  = run_mode_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        enable_d    = 1'b0;

        unique case (state_q)
            S_RESET_SEQ: state_d = S_IDLE;
            S_IDLE: begin
                if (step_pulse) begin
                    unique case (mode)
                        2'b00: enable_d = 1'b1;
                        2'b10: begin
                            if (burst_count != '0) begin
                                run_mode_d  = mode;
                                remaining_d = burst_count;
                                first_d     = 1'b1;
                                state_d     = S_RUN;
                            end
                        end
                        default: begin
                            run_mode_d = mode;
                            first_d    = 1'b1;
                            state_d    = S_RUN;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (halt_req || bp_hit) begin
                    state_d = S_HALTED;
                end else if (step_pulse) begin
                    state_d = S_IDLE;
                end else if (issue_req) begin
                    enable_d = 1'b1;
                    first_d  = 1'b0;
                    if (run_mode_q == 2'b10) begin
                        remaining_d = remaining_q - BURST_WIDTH'(1);
                        if (remaining_q == BURST_WIDTH'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_HALTED: begin
                if (step_pulse) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_reset_d = (state_d == S_RESET_SEQ);
        halted_d    = (state_d == S_HALTED);
        count_d     = count_q + {{(COUNT_WIDTH-1){1'b0}}, enable_d};
    end

    assign cpu_enable  = enable_q;
    assign cpu_reset   = cpu_reset_q;
    assign cycle_count = count_q;
    assign state       = state_q;
    assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_controller
// Purpose  : Self-checking bench: vector table, directed sequences and random
//            stimulus against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_step_controller;

    localparam int PW = 6;
    localparam int CW = 4;
    localparam int BW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic          step_pulse;
    logic          tick;
    logic [BW-1:0] burst_count;
    logic [PW-1:0] breakpoint;
    logic          bp_enable;
    logic [PW-1:0] pc;
    logic          halt_req;
    logic          cpu_enable;
    logic          cpu_reset;
    logic [CW-1:0] cycle_count;
    logic [1:0]    state;
    logic          halted;

    step_controller #(.PC_WIDTH(PW), .COUNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
        .clock(clock), .reset(reset), .mode(mode), .step_pulse(step_pulse),
        .tick(tick), .burst_count(burst_count), .breakpoint(breakpoint),
        .bp_enable(bp_enable), .pc(pc), .halt_req(halt_req),
        .cpu_enable(cpu_enable), .cpu_reset(cpu_reset),
        .cycle_count(cycle_count), .state(state), .halted(halted)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int dut_en = 0;
    bit pc_track = 0;

    // Reference model: 0 RESET_SEQ, 1 IDLE, 2 RUN, 3 HALTED
    int m_state = 0, m_count = 0, m_rem = 0, m_rmode = 0;
    bit m_en = 0, m_crst = 0, m_first = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic void model_update();
        bit hit;
        if (reset) begin
            m_state = 0; m_crst = 1; m_en = 0; m_count = 0;
            m_rem = 0; m_rmode = 0; m_first = 0;
        end else begin
            m_en = 0;
            m_crst = 0;
            case (m_state)
                0: m_state = 1;
                1: if (step_pulse) begin
                    if (mode == 2'd0) m_en = 1;
                    else if (mode == 2'd2) begin
                        if (burst_count != 0) begin
                            m_rem = int'(burst_count); m_rmode = 2; m_first = 1; m_state = 2;
                        end
                    end else begin
                        m_rmode = int'(mode); m_first = 1; m_state = 2;
                    end
                end
                2: begin
                    hit = bp_enable && (pc == breakpoint) && !m_first;
                    if (halt_req || hit) m_state = 3;
                    else if (step_pulse) m_state = 1;
                    else if (m_rmode == 3 || tick) begin
                        m_en = 1;
                        m_first = 0;
                        if (m_rmode == 2) begin
                            m_rem = m_rem - 1;
                            if (m_rem == 0) m_state = 1;
                        end
                    end
                end
                default: if (step_pulse) m_state = 1;
            endcase
            if (m_en) m_count = (m_count + 1) % (1 << CW);
        end
    endfunction

    // One clock: model follows the edge, outputs checked 1 time unit later
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("cpu_enable", 32'(cpu_enable), 32'(m_en));
        chk("cpu_reset", 32'(cpu_reset), 32'(m_crst));
        chk("cycle_count", 32'(cycle_count), 32'(m_count));
        chk("halted", 32'(halted), 32'(m_state == 3));
        if (cpu_enable) dut_en++;
        if (pc_track && m_en) pc = pc + PW'(4);
        step_pulse = 1'b0;
        tick       = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] md;
        logic       stp;
        logic       tck;
        logic [7:0] bc;
        logic       hlt;
        logic [1:0] e_state;
        logic       e_en;
        logic       e_crst;
        logic [3:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input int r, md, s, t, b, h, es, ee, ec, cn);
        vec_t v;
        v.rst = 1'(r); v.md = 2'(md); v.stp = 1'(s); v.tck = 1'(t);
        v.bc = 8'(b); v.hlt = 1'(h);
        v.e_state = 2'(es); v.e_en = 1'(ee); v.e_crst = 1'(ec); v.e_cnt = 4'(cn);
        return v;
    endfunction

    vec_t vt[17];

    initial begin
        reset = 1'b1; mode = 2'd0; step_pulse = 1'b0; tick = 1'b0;
        burst_count = '0; breakpoint = PW'(16); bp_enable = 1'b0;
        pc = '0; halt_req = 1'b0;

        //          rst md stp tck bc hlt | state en crst cnt
        vt[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        vt[1]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        vt[2]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        vt[4]  = mk(0, 0, 1, 0, 0, 0,   1, 1, 0, 1);
        vt[5]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1);
        vt[6]  = mk(0, 0, 0, 1, 0, 0,   1, 0, 0, 1);
        vt[7]  = mk(0, 0, 1, 0, 0, 0,   1, 1, 0, 2);
        vt[8]  = mk(0, 1, 0, 1, 0, 0,   1, 0, 0, 2);
        vt[9]  = mk(0, 2, 1, 0, 0, 0,   1, 0, 0, 2);
        vt[10] = mk(0, 2, 1, 0, 2, 0,   2, 0, 0, 2);
        vt[11] = mk(0, 2, 0, 1, 2, 0,   2, 1, 0, 3);
        vt[12] = mk(0, 2, 0, 0, 2, 0,   2, 0, 0, 3);
        vt[13] = mk(0, 2, 0, 1, 2, 0,   1, 1, 0, 4);
        vt[14] = mk(0, 1, 1, 0, 0, 0,   2, 0, 0, 4);
        vt[15] = mk(0, 1, 0, 1, 0, 1,   3, 0, 0, 4);
        vt[16] = mk(0, 1, 1, 0, 0, 0,   1, 0, 0, 4);

        #2;
        for (int i = 0; i < 17; i++) begin
            reset = vt[i].rst; mode = vt[i].md; step_pulse = vt[i].stp;
            tick = vt[i].tck; burst_count = vt[i].bc; halt_req = vt[i].hlt;
            step();
            chk($sformatf("vec%0d.state", i), 32'(state), 32'(vt[i].e_state));
            chk($sformatf("vec%0d.en", i), 32'(cpu_enable), 32'(vt[i].e_en));
            chk($sformatf("vec%0d.crst", i), 32'(cpu_reset), 32'(vt[i].e_crst));
            chk($sformatf("vec%0d.cnt", i), 32'(cycle_count), 32'(vt[i].e_cnt));
        end
        halt_req = 1'b0;

        // Manual step: three pulses ten cycles apart
        mode = 2'd0; dut_en = 0;
        repeat (3) begin
            step_pulse = 1'b1;
            step();
            repeat (9) step();
        end
        chk("manual.enables", 32'(dut_en), 32'd3);
        chk("manual.count", 32'(cycle_count), 32'd7);
        chk("manual.state", 32'(state), 32'd1);

        // Burst of 5 against 8 ticks, then burst of 0
        mode = 2'd2; burst_count = 8'd5; step_pulse = 1'b1;
        step();
        dut_en = 0;
        repeat (8) begin
            tick = 1'b1;
            step(); step(); step();
        end
        chk("burst.enables", 32'(dut_en), 32'd5);
        chk("burst.state", 32'(state), 32'd1);
        chk("burst.count", 32'(cycle_count), 32'd12);
        burst_count = 8'd0; step_pulse = 1'b1;
        step();
        chk("burst0.state", 32'(state), 32'd1);
        step();
        chk("burst0.state2", 32'(state), 32'd1);

        // Run to breakpoint: start on the breakpoint, halt after the PC wraps
        mode = 2'd3; bp_enable = 1'b1; breakpoint = PW'(16); pc = PW'(16);
        pc_track = 1; step_pulse = 1'b1;
        step();
        dut_en = 0;
        repeat (25) step();
        chk("bp.enables", 32'(dut_en), 32'd16);
        chk("bp.halted", 32'(halted), 32'd1);
        chk("bp.state", 32'(state), 32'd3);
        step_pulse = 1'b1;
        step();
        chk("bp.resume_state", 32'(state), 32'd1);
        chk("bp.resume_halted", 32'(halted), 32'd0);
        pc_track = 0; bp_enable = 1'b0;

        // Free-run: 4 ticks, halt on a tick, stop on a tick
        mode = 2'd1; step_pulse = 1'b1;
        step();
        dut_en = 0;
        repeat (4) begin
            tick = 1'b1;
            step(); step();
        end
        chk("free.enables", 32'(dut_en), 32'd4);
        halt_req = 1'b1; tick = 1'b1;
        step();
        chk("free.halt_en", 32'(cpu_enable), 32'd0);
        chk("free.halt_state", 32'(state), 32'd3);
        halt_req = 1'b0;
        step();
        step_pulse = 1'b1; step();
        step_pulse = 1'b1; step();
        step_pulse = 1'b1; tick = 1'b1;
        step();
        chk("free.stop_state", 32'(state), 32'd1);
        chk("free.stop_en", 32'(cpu_enable), 32'd0);

        // Counter wrap: 17 enables from a fresh reset
        reset = 1'b1; step();
        reset = 1'b0; step();
        mode = 2'd3; step_pulse = 1'b1;
        step();
        dut_en = 0;
        repeat (17) step();
        step_pulse = 1'b1;
        step();
        chk("wrap.enables", 32'(dut_en), 32'd17);
        chk("wrap.count", 32'(cycle_count), 32'd1);
        chk("wrap.state", 32'(state), 32'd1);

        // Reset in the middle of a burst
        mode = 2'd2; burst_count = 8'd5; step_pulse = 1'b1;
        step();
        tick = 1'b1; step();
        step();
        tick = 1'b1; step();
        reset = 1'b1; step();
        chk("midrst.state", 32'(state), 32'd0);
        chk("midrst.crst", 32'(cpu_reset), 32'd1);
        chk("midrst.count", 32'(cycle_count), 32'd0);
        reset = 1'b0; step();
        chk("midrst.idle", 32'(state), 32'd1);
        tick = 1'b1; step();
        chk("midrst.no_en", 32'(cpu_enable), 32'd0);
        chk("midrst.count2", 32'(cycle_count), 32'd0);

        // Randomized stimulus against the model
        breakpoint = PW'(8);
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            mode        = 2'($urandom_range(0, 3));
            step_pulse  = ($urandom_range(0, 9) == 0);
            tick        = ($urandom_range(0, 2) == 0);
            burst_count = 8'($urandom_range(0, 3));
            halt_req    = ($urandom_range(0, 19) == 0);
            bp_enable   = 1'($urandom_range(0, 1));
            pc          = PW'(4 * $urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
